// File: rtl/regfile_sb.sv
// Register file with a pending-write scoreboard and a sequenced zero-fill sweep.
// Register 0 is hardwired to zero and is never busy. Both reads are combinational.
// A same-cycle writeback is forwarded to the read ports while idle.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            wr_en,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            clr_req,
  output logic            ready
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wr_ok;

  assign ready = (state_q == StIdle);
  // Writeback qualified for both the bypass and the array update.
  assign wr_ok = wr_en && ready && (rd != '0);

  // Combinational read ports with writeback bypass; regs_q[0] stays zero forever.
  always_comb begin
    op_a = regs_q[rs1];
    op_b = regs_q[rs2];
    if (wr_ok && (rd == rs1)) op_a = data;
    if (wr_ok && (rd == rs2)) op_b = data;
  end

  // Busy outputs show the registered scoreboard only, no same-cycle forwarding.
  assign busy_a = busy_q[rs1];
  assign busy_b = busy_q[rs2];

  // Next-state logic for the FSM, sweep counter, register array and scoreboard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (wr_ok) begin
          regs_d[rd] = data;
          busy_d[rd] = 1'b0;
        end
        // Applied after the writeback clear so that a same-register issue wins.
        if (iss_en && (iss_rd != '0)) begin
          busy_d[iss_rd] = 1'b1;
        end
        if (clr_req) begin
          state_d = StSweep;
          cnt_d   = AW'(1);
          busy_d  = '0;
        end
      end
      StSweep: begin
        regs_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + AW'(1);  // wraps to 0 after NREG-1
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; synchronous reset also aborts a sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: runs the same scenarios on a 32x32 and a 16x64 instance.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, iss_rd = '0;
  logic [63:0] data = '0;
  logic        wr_en = 1'b0, iss_en = 1'b0, clr_req = 1'b0;

  logic [31:0] op_a32, op_b32;
  logic [63:0] op_a64, op_b64;
  logic        busy_a32, busy_b32, busy_a64, busy_b64, ready32, ready64;

  logic        sel = 1'b0;  // 0: 32-bit/32-reg instance, 1: 64-bit/16-reg instance
  logic [63:0] op_a, op_b;
  logic        busy_a, busy_b, ready;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5)) u_dut32 (
    .clk     (clk),
    .rst     (rst),
    .rs1     (rs1),
    .rs2     (rs2),
    .op_a    (op_a32),
    .op_b    (op_b32),
    .busy_a  (busy_a32),
    .busy_b  (busy_b32),
    .wr_en   (wr_en),
    .rd      (rd),
    .data    (data[31:0]),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .clr_req (clr_req),
    .ready   (ready32)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .AW(4)) u_dut64 (
    .clk     (clk),
    .rst     (rst),
    .rs1     (rs1[3:0]),
    .rs2     (rs2[3:0]),
    .op_a    (op_a64),
    .op_b    (op_b64),
    .busy_a  (busy_a64),
    .busy_b  (busy_b64),
    .wr_en   (wr_en),
    .rd      (rd[3:0]),
    .data    (data),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd[3:0]),
    .clr_req (clr_req),
    .ready   (ready64)
  );

  assign op_a   = sel ? op_a64 : {32'h0, op_a32};
  assign op_b   = sel ? op_b64 : {32'h0, op_b32};
  assign busy_a = sel ? busy_a64 : busy_a32;
  assign busy_b = sel ? busy_b64 : busy_b32;
  assign ready  = sel ? ready64 : ready32;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cfg %0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    iss_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic run_phase(input int nreg, input logic [63:0] dval);
    logic [63:0] mask;
    logic [63:0] dexp;
    int          n;
    mask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    dexp = dval & mask;

    // Reset state
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs1 = 5'd5; rs2 = 5'd9;
    #1;
    check("rst_op_a", op_a, 64'h0);
    check("rst_op_b", op_b, 64'h0);
    check("rst_busy_a", {63'h0, busy_a}, 64'h0);
    check("rst_busy_b", {63'h0, busy_b}, 64'h0);
    check("rst_ready", {63'h0, ready}, 64'h1);

    // Write with same-cycle bypass on port B, no bypass on an unrelated port A address
    wr_en = 1'b1; rd = 5'd5; data = dval; rs2 = 5'd5; rs1 = 5'd3;
    #1;
    check("bypass_b", op_b, dexp);
    check("no_bypass_a", op_a, 64'h0);
    tick();
    idle_inputs();
    rs1 = 5'd5;
    #1;
    check("read_after_wr", op_a, dexp);

    // Register 0: no write, no bypass, never busy
    wr_en = 1'b1; rd = 5'd0; data = '1; iss_en = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    #1;
    check("r0_no_bypass", op_a, 64'h0);
    tick();
    idle_inputs();
    #1;
    check("r0_read", op_a, 64'h0);
    check("r0_busy", {63'h0, busy_a}, 64'h0);

    // Scoreboard set / clear / issue-wins
    iss_en = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    #1;
    check("busy_no_fwd_set", {63'h0, busy_a}, 64'h0);
    tick();
    idle_inputs();
    #1;
    check("busy_set", {63'h0, busy_a}, 64'h1);
    wr_en = 1'b1; rd = 5'd7; data = 64'h77;
    #1;
    check("busy_no_fwd_clr", {63'h0, busy_a}, 64'h1);
    tick();
    idle_inputs();
    #1;
    check("busy_clr", {63'h0, busy_a}, 64'h0);
    check("r7_data", op_a, 64'h77);
    wr_en = 1'b1; rd = 5'd7; data = 64'h1234; iss_en = 1'b1; iss_rd = 5'd7;
    tick();
    idle_inputs();
    #1;
    check("issue_wins_busy", {63'h0, busy_a}, 64'h1);
    check("issue_wins_data", op_a, 64'h1234);

    // Fill registers with their index, then read back
    for (int i = 1; i < nreg; i++) begin
      wr_en = 1'b1; rd = 5'(i); data = 64'(i);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < nreg; i++) begin
      rs1 = 5'(i);
      #1;
      check("fill_read", op_a, 64'(i));
    end

    // Mark r3 busy, then clr_req together with a write to r2 and an issue to r6
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    idle_inputs();
    rs1 = 5'd3;
    clr_req = 1'b1; wr_en = 1'b1; rd = 5'd2; data = 64'hAA; iss_en = 1'b1; iss_rd = 5'd6;
    #1;
    check("busy3_pre_sweep", {63'h0, busy_a}, 64'h1);
    tick();
    idle_inputs();
    #1;
    check("sweep_ready_low", {63'h0, ready}, 64'h0);
    check("sweep_busy_clr", {63'h0, busy_a}, 64'h0);
    rs1 = 5'd2;
    #1;
    check("clr_with_wr", op_a, 64'hAA);

    // Run the sweep, poking ignored inputs and partial reads on the fifth sweep cycle
    n = 0;
    while (!ready && n < 100) begin
      if (n == 4) begin
        wr_en = 1'b1; rd = 5'd1; data = 64'h5555; iss_en = 1'b1; iss_rd = 5'd1;
        clr_req = 1'b1; rs2 = 5'd1; rs1 = 5'(nreg - 1);
        #1;
        check("sweep_no_bypass", op_b, 64'h0);
        check("sweep_partial_rd", op_a, 64'(nreg - 1));
      end else begin
        idle_inputs();
      end
      tick();
      n++;
    end
    idle_inputs();
    check("sweep_len", 64'(n), 64'(nreg - 1));
    check("sweep_ready_hi", {63'h0, ready}, 64'h1);
    for (int i = 0; i < nreg; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      #1;
      check("post_sweep_rd", op_a, 64'h0);
      check("post_sweep_busy", {63'h0, busy_b}, 64'h0);
    end

    // Reset aborts a sweep at its tenth cycle
    wr_en = 1'b1; rd = 5'(nreg - 2); data = 64'h99;
    tick();
    idle_inputs();
    iss_en = 1'b1; iss_rd = 5'd12;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    idle_inputs();
    repeat (9) tick();
    #1;
    check("abort_pre_ready", {63'h0, ready}, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rs1 = 5'(nreg - 2); rs2 = 5'd12;
    #1;
    check("abort_ready", {63'h0, ready}, 64'h1);
    check("abort_reg_zero", op_a, 64'h0);
    check("abort_busy", {63'h0, busy_b}, 64'h0);
    wr_en = 1'b1; rd = 5'd6; data = dval;
    tick();
    idle_inputs();
    rs1 = 5'd6;
    #1;
    check("abort_wr_after", op_a, dexp);
  endtask

  initial begin
    sel = 1'b0;
    run_phase(32, 64'h0000_0000_DEAD_BEEF);
    sel = 1'b1;
    run_phase(16, 64'h0123_4567_89AB_CDEF);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREG, default 32, register count; SHALL be a power of two, at least 2.
REQ-003 Parameter AW, default 5, address width; SHALL equal log2(NREG).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rs1, rs2  in  AW  read addresses, ports A and B.
REQ-007 op_a, op_b  out  XLEN  read data, ports A and B.
REQ-008 busy_a, busy_b  out  1  scoreboard pending bit for rs1 and rs2.
REQ-009 wr_en  in  1  writeback strobe.
REQ-010 rd  in  AW  writeback address.
REQ-011 data  in  XLEN  writeback data.
REQ-012 iss_en  in  1  issue strobe; marks iss_rd pending.
REQ-013 iss_rd  in  AW  issue destination.
REQ-014 clr_req  in  1  request for a sequenced zero-fill of all registers.
REQ-015 ready  out  1  high when idle (no sweep in progress).

Function
REQ-016 Register 0 SHALL read as zero, SHALL ignore writes, and SHALL never be busy.
REQ-017 Reads SHALL be combinational: op_a = reg[rs1], op_b = reg[rs2].
REQ-018 Bypass: if wr_en, ready, rd!=0 and rd==rsN, opN SHALL equal data in the same cycle.
REQ-019 Write: if wr_en, ready and rd!=0, reg[rd] <= data at the next edge.
REQ-020 Scoreboard: if iss_en, ready and iss_rd!=0, busy[iss_rd] <= 1 at the next edge.
REQ-021 If wr_en, ready and rd!=0, busy[rd] <= 0, unless rule REQ-022 applies.
REQ-022 If iss_en and wr_en target the same nonzero register in one cycle, busy SHALL end set (issue wins); the data write still occurs.
REQ-023 busy_N SHALL reflect the registered busy bit, with no bypass of a same-cycle clear or set.
REQ-024 FSM states: IDLE and SWEEP.
REQ-025 IDLE -> SWEEP when clr_req=1; the sweep counter loads 1.
REQ-026 In SWEEP, each cycle: reg[cnt] <= 0, busy[cnt] <= 0, cnt <= cnt+1.
REQ-027 The last sweep cycle has cnt==NREG-1; the FSM then returns to IDLE and cnt wraps to 0; sweep duration is NREG-1 cycles.
REQ-028 On the IDLE->SWEEP edge, all busy bits SHALL clear immediately.
REQ-029 ready SHALL equal (state==IDLE).
REQ-030 In SWEEP, wr_en, iss_en and clr_req SHALL be ignored, and bypass SHALL be disabled.
REQ-031 In SWEEP, reads remain valid and return the current register contents (partially cleared).
REQ-032 clr_req asserted together with wr_en or iss_en in IDLE: the write and issue SHALL take effect on that edge, then the sweep begins; the sweep subsequently zeroes the written register.

Reset
REQ-033 With rst high at an edge: all registers <= 0, all busy <= 0, state <= IDLE, cnt <= 0.
REQ-034 rst SHALL override every other input, including a sweep in progress (abort).
REQ-035 After the reset edge: op_a=op_b=0, busy_a=busy_b=0, ready=1.

Verification
REQ-036 Reset; wr rd=5 data=0xDEADBEEF; next cycle rs1=5 -> op_a=0xDEADBEEF; during the write cycle with rs2=5 -> op_b=0xDEADBEEF (bypass).
REQ-037 wr rd=0 data=0xFFFFFFFF; iss_rd=0 -> op_a(rs1=0)=0 and busy_a=0 thereafter.
REQ-038 iss_rd=7 -> busy_a(rs1=7)=1 next cycle; later wr rd=7 -> busy_a=0 next cycle; iss_rd=7 and wr rd=7 in the same cycle -> busy stays 1, reg[7] updated.
REQ-039 Fill regs 1..31 with index values; pulse clr_req -> ready=0 for 31 cycles; wr_en during the sweep is ignored; ready=1 after; all reads return 0; busy all 0.
REQ-040 Start a sweep, assert rst at sweep cycle 10 -> next cycle ready=1, all regs 0, and a subsequent write works normally.
REQ-041 Regression with XLEN=64, NREG=16: same scenarios, data 0x0123456789ABCDEF, sweep duration 15 cycles.
